// File: rtl/gpr_wb_arbiter.sv
// Writeback arbiter for the GPR write port: ALU vs. LSU with ALU anti-starvation,
// plus a pending-load scoreboard that drives decode's RAW hazard stall.
module gpr_wb_arbiter #(
    parameter int ARCH_WIDTH   = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  aluValid,
    output logic                  aluReady,
    input  logic [4:0]            aluRd,
    input  logic [ARCH_WIDTH-1:0] aluData,
    input  logic                  lsuValid,
    output logic                  lsuReady,
    input  logic [4:0]            lsuRd,
    input  logic [ARCH_WIDTH-1:0] lsuData,
    input  logic                  issueEn,
    input  logic [4:0]            issueRd,
    input  logic [4:0]            rs1,
    input  logic [4:0]            rs2,
    output logic                  hazard,
    output logic [4:0]            gprRd,
    output logic                  gprWEn,
    output logic [ARCH_WIDTH-1:0] gprWData
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0]            starve_cnt_q;
    logic [3:0]            starve_cnt_d;
    logic [31:0]           pending_q;
    logic [31:0]           pending_d;
    logic [31:0]           set_vec;
    logic [31:0]           clr_vec;
    logic                  gpr_wen_q;
    logic [4:0]            gpr_rd_q;
    logic [ARCH_WIDTH-1:0] gpr_wdata_q;

    logic                  starved;
    logic                  alu_fire;
    logic                  lsu_fire;
    logic                  wb_fire;
    logic [4:0]            wb_rd;
    logic [ARCH_WIDTH-1:0] wb_data;
    logic                  port_hit;

    // LSU has priority until the ALU has been denied STARVE_LIMIT cycles in a row.
    assign starved  = (starve_cnt_q == LIMIT);
    assign aluReady = aluValid & (~lsuValid | starved);
    assign lsuReady = lsuValid & ~(aluValid & starved);

    assign alu_fire = aluValid & aluReady;
    assign lsu_fire = lsuValid & lsuReady;
    assign wb_fire  = alu_fire | lsu_fire;
    assign wb_rd    = alu_fire ? aluRd : lsuRd;
    assign wb_data  = alu_fire ? aluData : lsuData;

    always_comb begin
        starve_cnt_d = 4'd0;
        if (aluValid && !aluReady) begin
            starve_cnt_d = (starve_cnt_q >= LIMIT) ? LIMIT : starve_cnt_q + 4'd1;
        end
    end

    // x0 is never tracked, so bit 0 stays constant zero.
    assign set_vec[0]   = 1'b0;
    assign clr_vec[0]   = 1'b0;
    assign pending_d[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 1; gi < 32; gi++) begin : g_sb
            assign set_vec[gi]   = issueEn & (issueRd == 5'(gi));
            assign clr_vec[gi]   = lsu_fire & (lsuRd == 5'(gi));
            assign pending_d[gi] = set_vec[gi] | (pending_q[gi] & ~clr_vec[gi]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rstN) begin
            starve_cnt_q <= 4'd0;
            pending_q    <= 32'd0;
            gpr_wen_q    <= 1'b0;
            gpr_rd_q     <= 5'd0;
            gpr_wdata_q  <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            pending_q    <= pending_d;
            gpr_wen_q    <= wb_fire && (wb_rd != 5'd0);
            if (wb_fire) begin
                gpr_rd_q    <= wb_rd;
                gpr_wdata_q <= wb_data;
            end
        end
    end

    // A write sitting on the port has not reached the register file yet.
    assign port_hit = gpr_wen_q && (gpr_rd_q != 5'd0) &&
                      ((gpr_rd_q == rs1) || (gpr_rd_q == rs2));
    assign hazard   = pending_q[rs1] | pending_q[rs2] | port_hit;

    assign gprWEn   = gpr_wen_q;
    assign gprRd    = gpr_rd_q;
    assign gprWData = gpr_wdata_q;

endmodule

// File: doc/gpr_wb_arbiter.md
Name: gpr_wb_arbiter

Overview:
- Shares the single write port of the 32-entry GPR file between two writeback requesters: the ALU (single-cycle) and the load/store unit (variable latency).
- Keeps a 32-bit pending-load scoreboard so that decode can stall on read-after-write hazards against outstanding loads.
- Sits between the execute/memory units and the GPR file's rd/wEn/wData inputs. Decode reads its hazard output.

Parameters:
- ARCH_WIDTH, 64, data width of the GPR file and writeback data.
- STARVE_LIMIT, 4, consecutive cycles an ALU request may be denied before it is forced a grant; legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rstN  input  1  synchronous active-low reset.
- aluValid  input  1  ALU writeback request.
- aluReady  output  1  ALU request accepted this cycle.
- aluRd  input  5  ALU destination register.
- aluData  input  ARCH_WIDTH  ALU writeback data.
- lsuValid  input  1  LSU writeback request.
- lsuReady  output  1  LSU request accepted this cycle.
- lsuRd  input  5  LSU destination register.
- lsuData  input  ARCH_WIDTH  LSU writeback data.
- issueEn  input  1  a load is issued this cycle.
- issueRd  input  5  destination of the issued load.
- rs1  input  5  decode source register 1.
- rs2  input  5  decode source register 2.
- hazard  output  1  rs1 or rs2 depends on a not-yet-written load.
- gprRd  output  5  GPR write address (registered).
- gprWEn  output  1  GPR write enable (registered).
- gprWData  output  ARCH_WIDTH  GPR write data (registered).

Behaviour:
- Reset (rstN=0 at a clk edge): gprWEn=0, gprRd=0, gprWData=0, pending vector=0, starve counter=0. Any in-flight write is dropped.
- aluReady, lsuReady and hazard are combinational. They may be non-zero during reset, but all state ignores them while rstN=0.
- Handshake: a transfer occurs when valid && ready at a clk edge. The requester holds rd and data stable while valid && !ready.
- Grant rule (evaluated each cycle):
  - Only one requester valid: that requester gets ready=1.
  - Both valid: LSU wins (lsuReady=1, aluReady=0) unless starveCnt == STARVE_LIMIT. In that case the ALU wins and the LSU waits.
  - Never both readies high in the same cycle.
- Starve counter (4 bits):
  - Increments when aluValid && !aluReady.
  - Resets to 0 when the ALU handshakes or aluValid=0.
  - Saturates at STARVE_LIMIT.
- Write port latency is 1 cycle. The transfer accepted at edge N drives gprWEn=1 with gprRd/gprWData from edge N until edge N+1. The GPR file commits at edge N+1.
  - No transfer at an edge: gprWEn=0; gprRd and gprWData hold their previous values.
- x0 handling: a transfer with rd=0 still handshakes, but gprWEn stays 0 for it. x0 is never marked pending.
- Scoreboard, pending[31:0]:
  - Set: issueEn && issueRd!=0 sets pending[issueRd] at the edge.
  - Clear: an LSU transfer accepted at an edge clears pending[lsuRd] at that same edge.
  - Simultaneous set and clear on the same index: set wins (new load outstanding).
  - Issuing to an already-pending rd leaves it set. There is no counting; upstream guarantees this case never occurs.
- hazard = pending[rs1] | pending[rs2] | (gprWEn && gprRd!=0 && (gprRd==rs1 || gprRd==rs2)).
  - The second term covers the cycle in which the write is on the port but not yet committed.
  - rs=0 never raises hazard.
- The ALU path does not touch the scoreboard.

Test Plan:
- Reset then idle: rstN low for 2 cycles with aluValid=1 → gprWEn=0, pending=0. After release, aluRd=5 with aluData=0x1234 handshakes on the first edge, and gprWEn=1, gprRd=5, gprWData=0x1234 for exactly one cycle.
- Contention: aluValid and lsuValid both held high for 8 cycles (STARVE_LIMIT=4) → LSU granted for 4 consecutive cycles, ALU granted on the 5th, then LSU again. The two readies are never high together.
- Scoreboard: issueEn with issueRd=7, then rs1=7 → hazard=1 until the LSU handshake for rd=7; hazard is still 1 on the following cycle (gprWEn, rd 7); hazard=0 the cycle after.
- Simultaneous set and clear: LSU writeback to rd=9 at the same edge as issueEn with issueRd=9 → pending[9] stays 1.
- x0: ALU then LSU writebacks to rd=0, and issueEn with issueRd=0 → both readies assert, gprWEn stays 0, and hazard=0 with rs1=rs2=0.
- Reset mid-operation: rstN=0 at the edge after an LSU accept to rd=3, with pending[3] set by an earlier issue → gprWEn=0 next cycle and pending=0.
